// File: rtl/wrr_input_arbiter_param.sv
// wrr_input_arbiter_param
// Packet-granular weighted round-robin arbiter. NUM_QUEUES input streams are
// each buffered in a small first-word-fall-through FIFO and merged into one
// output stream. Queue i may send up to weights[i] whole packets per visit;
// a weight of 0 disables the queue. Empty or disabled queues are skipped one
// per cycle. Define WRR_ARB_STATS_EN to build per-queue packet counters.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_data, in_ctrl, in_wr    per-queue input words; queue i at [i*W +: W]
//   in_rdy                     per-queue ready, low when the FIFO is nearly full
//   weights                    packets per round for each queue (sampled on reload)
//   out_data, out_ctrl, out_wr registered output stream
//   out_rdy                    downstream ready
//   cur_queue                  queue the arbiter currently points at
//   eop                        pulse with the out_wr of a packet's last word
//   stat_sel, stat_count       packet count readback (0 without WRR_ARB_STATS_EN)
module wrr_input_arbiter_param #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned NUM_QUEUES      = 8,
  parameter int unsigned WEIGHT_WIDTH    = 8,
  parameter int unsigned FIFO_DEPTH_BITS = 2,
  parameter int unsigned QW              = (NUM_QUEUES > 2) ? $clog2(NUM_QUEUES) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0]   in_ctrl,
  input  logic [NUM_QUEUES-1:0]              in_wr,
  output logic [NUM_QUEUES-1:0]              in_rdy,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weights,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [CTRL_WIDTH-1:0]              out_ctrl,
  output logic                               out_wr,
  input  logic                               out_rdy,
  output logic [QW-1:0]                      cur_queue,
  output logic                               eop,
  input  logic [QW-1:0]                      stat_sel,
  output logic [31:0]                        stat_count
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned CNT_W = FIFO_DEPTH_BITS + 1;

  typedef enum logic [0:0] {SELECT, WR_PKT} state_t;

  logic [DATA_WIDTH-1:0]   head_data [NUM_QUEUES];
  logic [CTRL_WIDTH-1:0]   head_ctrl [NUM_QUEUES];
  logic [WEIGHT_WIDTH-1:0] weight    [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]   empty;
  logic [NUM_QUEUES-1:0]   pop;

  state_t                  state, state_next;
  logic [QW-1:0]           ptr, ptr_next, ptr_inc;
  logic [WEIGHT_WIDTH-1:0] credit, credit_next;
  logic [CTRL_WIDTH-1:0]   prev_ctrl, prev_ctrl_next;
  logic                    pop_any, last_pop;
  logic [DATA_WIDTH-1:0]   data_sel;
  logic [CTRL_WIDTH-1:0]   ctrl_sel;

  // Per-queue FWFT FIFO; in_rdy is registered from the next occupancy.
  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_fifo
    logic [DATA_WIDTH+CTRL_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]                 count, count_next;
    logic                             nearly_full, do_wr, do_rd;

    assign do_wr = in_wr[i] && (count != CNT_W'(DEPTH));
    assign do_rd = pop[i];

    always_comb begin
      count_next = count;
      if (do_wr && !do_rd)      count_next = count + CNT_W'(1);
      else if (!do_wr && do_rd) count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        nearly_full <= 1'b0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
        if (do_rd) rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
        count       <= count_next;
        nearly_full <= (count_next >= CNT_W'(DEPTH - 1));
      end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= {in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH],
                                 in_data[i*DATA_WIDTH +: DATA_WIDTH]};
    end

    assign {head_ctrl[i], head_data[i]} = mem[rd_ptr];
    assign empty[i]  = (count == '0);
    assign in_rdy[i] = !nearly_full;
    assign weight[i] = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

  assign ptr_inc  = (ptr == QW'(NUM_QUEUES - 1)) ? '0 : ptr + QW'(1);
  assign data_sel = head_data[ptr];
  assign ctrl_sel = head_ctrl[ptr];

  // Next-state: queue scan, packet forwarding and credit accounting.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    credit_next    = credit;
    prev_ctrl_next = prev_ctrl;
    pop_any        = 1'b0;
    last_pop       = 1'b0;
    case (state)
      SELECT: begin
        if (empty[ptr] || (weight[ptr] == '0) || (credit == '0)) begin
          ptr_next    = ptr_inc;
          credit_next = weight[ptr_inc];
        end else if (out_rdy) begin
          pop_any        = 1'b1;
          prev_ctrl_next = CTRL_WIDTH'(1);
          state_next     = WR_PKT;
        end
      end
      WR_PKT: begin
        if (out_rdy && !empty[ptr]) begin
          pop_any = 1'b1;
          // Last word: non-zero ctrl following a body word.
          if ((ctrl_sel != '0) && (prev_ctrl == '0)) begin
            last_pop   = 1'b1;
            state_next = SELECT;
            if (credit == WEIGHT_WIDTH'(1)) begin
              ptr_next    = ptr_inc;
              credit_next = weight[ptr_inc];
            end else begin
              credit_next = credit - WEIGHT_WIDTH'(1);
            end
          end else begin
            prev_ctrl_next = ctrl_sel;
          end
        end
      end
      default: state_next = SELECT;
    endcase
    pop = NUM_QUEUES'(pop_any) << ptr;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SELECT;
      ptr       <= '0;
      credit    <= weight[0];
      prev_ctrl <= CTRL_WIDTH'(1);
      out_wr    <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      eop       <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      credit    <= credit_next;
      prev_ctrl <= prev_ctrl_next;
      out_wr    <= pop_any;
      eop       <= last_pop;
      if (pop_any) begin
        out_data <= data_sel;
        out_ctrl <= ctrl_sel;
      end
    end
  end

  assign cur_queue = ptr;

`ifdef WRR_ARB_STATS_EN
  logic [31:0] pkt_count [NUM_QUEUES];
  logic [31:0] stat_q;

  // Saturating per-queue packet counters with registered readback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_QUEUES); i++) pkt_count[i] <= '0;
      stat_q <= '0;
    end else begin
      if (last_pop && (pkt_count[ptr] != 32'hFFFF_FFFF))
        pkt_count[ptr] <= pkt_count[ptr] + 32'd1;
      stat_q <= pkt_count[stat_sel];
    end
  end

  assign stat_count = stat_q;
`else
  logic stat_sel_unused;
  assign stat_sel_unused = ^stat_sel;
  assign stat_count      = 32'd0;
`endif

endmodule
